register_file: RTL

- Parametrised multi-entry register file for the 8-bit RISC datapath. It generalises the single load-enabled 8-bit register to DEPTH entries of WIDTH bits.
- One write port supports four write operations: load, increment, decrement and entry clear. A one-cycle global clear wipes every entry.
- Two registered read ports, with optional write-to-read bypass.
- Per-entry valid tracking and an arithmetic wrap flag, for use by the control unit and accumulator path.

---
 rtl/register_file.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   Multi-entry register file for the 8-bit RISC datapath. DEPTH entries of
//   WIDTH bits, one write port (load / increment / decrement / entry clear),
//   a one-cycle global clear, two registered read ports with optional
//   write-to-read bypass, per-entry valid bits and an increment/decrement
//   wrap pulse.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_     : asynchronous active-low reset
//   clr      : synchronous global clear (wins over a write in the same cycle)
//   we       : write enable
//   wop      : 00 load wdata, 01 increment, 10 decrement, 11 clear entry
//   waddr    : write address (ignored when >= DEPTH)
//   wdata    : load data, used only for wop = 00
//   raddr_a  : port A read address
//   raddr_b  : port B read address
//   rdata_a  : registered port A data (RST_VAL for out-of-range addresses)
//   rdata_b  : registered port B data
//   valid_a  : registered port A entry-written flag
//   valid_b  : registered port B entry-written flag
//   wrap     : one-cycle pulse after an accepted increment/decrement wrapped
// ---------------------------------------------------------------------------
module register_file #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 8,
  parameter int               AW      = 3,
  parameter int               BYPASS  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clr,
  input  logic             we,
  input  logic [1:0]       wop,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             valid_a,
  output logic             valid_b,
  output logic             wrap
);

  localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;

  logic             wr_hit;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic             nxt_vld;
  logic             wrap_nxt;
  logic [WIDTH-1:0] rd_a_p0;
  logic [WIDTH-1:0] rd_b_p0;
  logic             vld_a_p0;
  logic             vld_b_p0;

  // Addresses at or above DEPTH have no backing entry.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_A;
  endfunction

  // Value a read port captures this cycle. With bypass the read observes the
  // post-edge state (clear wins, then the accepted write); without bypass it
  // observes the array exactly as it stands before the edge.
  function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] a);
    logic [WIDTH-1:0] r;
    r = RST_VAL;
    if (in_range(a)) begin
      if (BYPASS != 0 && clr)
        r = RST_VAL;
      else if (BYPASS != 0 && wr_hit && waddr == a)
        r = nxt;
      else
        r = mem[a];
    end
    return r;
  endfunction

  function automatic logic rd_vld(input logic [AW-1:0] a);
    logic r;
    r = 1'b0;
    if (in_range(a)) begin
      if (BYPASS != 0 && clr)
        r = 1'b0;
      else if (BYPASS != 0 && wr_hit && waddr == a)
        r = nxt_vld;
      else
        r = vld[a];
    end
    return r;
  endfunction

  // Stage p0: write-op evaluation and read-port selection (combinational)
  always_comb begin
    wr_hit   = we && !clr && in_range(waddr);
    cur      = in_range(waddr) ? mem[waddr] : RST_VAL;
    nxt      = cur;
    nxt_vld  = 1'b1;
    wrap_nxt = 1'b0;
    case (wop)
      OP_LOAD: nxt = wdata;
      OP_INC: begin
        nxt      = cur + 1'b1;
        wrap_nxt = (cur == {WIDTH{1'b1}});
      end
      OP_DEC: begin
        nxt      = cur - 1'b1;
        wrap_nxt = (cur == '0);
      end
      OP_CLR: begin
        nxt     = RST_VAL;
        nxt_vld = 1'b0;
      end
      default: nxt = cur;
    endcase
  end

  always_comb begin
    rd_a_p0  = rd_data(raddr_a);
    rd_b_p0  = rd_data(raddr_b);
    vld_a_p0 = rd_vld(raddr_a);
    vld_b_p0 = rd_vld(raddr_b);
  end

  // Stage p1: array update and registered outputs
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      vld     <= '0;
      rdata_a <= RST_VAL;
      rdata_b <= RST_VAL;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      rdata_a <= rd_a_p0;
      rdata_b <= rd_b_p0;
      valid_a <= vld_a_p0;
      valid_b <= vld_b_p0;
      // wr_hit is already low under clr or an out-of-range address.
      wrap    <= wr_hit && wrap_nxt;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
        vld <= '0;
      end else if (wr_hit) begin
        mem[waddr] <= nxt;
        vld[waddr] <= nxt_vld;
      end
    end
  end

endmodule
